// File: rtl/gal_olmc_readback_if.sv
// gal_olmc_readback_if: capture request, macrocell snapshot inputs and serial readback handshake
interface gal_olmc_readback_if #(
    parameter int N_OLMC = 8
);
    logic              START;
    logic [N_OLMC-1:0] CFG_REG;
    logic [N_OLMC-1:0] CFG_INV;
    logic [N_OLMC-1:0] PIN;
    logic              SO;
    logic              SV;
    logic              SR;
    logic              BUSY;
    logic              DONE;

    modport master (
        output START, CFG_REG, CFG_INV, PIN, SR,
        input  SO, SV, BUSY, DONE
    );

    modport slave (
        input  START, CFG_REG, CFG_INV, PIN, SR,
        output SO, SV, BUSY, DONE
    );
endinterface

// File: rtl/gal_olmc_readback.sv
// gal_olmc_readback: snapshots OLMC config/pin bits and streams them as a framed, parity-protected serial word
module gal_olmc_readback #(
    parameter int          N_OLMC = 8,
    parameter logic [3:0]  HEADER = 4'b1010
) (
    input logic                 C,
    input logic                 R,
    gal_olmc_readback_if.slave  bus
);
    localparam int L  = 4 + 3 * N_OLMC + 1;
    localparam int CW = $clog2(L);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t          state_q;
    logic [L-1:0]    sh_q;
    logic [L-1:0]    frame_d;
    logic [CW-1:0]   cnt_q;
    logic            so_q;
    logic            sv_q;
    logic            busy_q;
    logic            done_q;

    // Assemble the frame with the first bit to send at index 0: header MSB first, per-cell triplets, even parity
    always_comb begin
        frame_d = '0;
        for (int k = 0; k < 4; k++) frame_d[k] = HEADER[3-k];
        for (int i = 0; i < N_OLMC; i++) begin
            frame_d[4+3*i]   = bus.CFG_REG[i];
            frame_d[4+3*i+1] = bus.CFG_INV[i];
            frame_d[4+3*i+2] = bus.PIN[i];
        end
        frame_d[L-1] = ^{bus.CFG_REG, bus.CFG_INV, bus.PIN};
    end

    // Readback sequencer: capture in IDLE, shift one bit per handshake, one-cycle DONE in FIN
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            so_q    <= 1'b0;
            sv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.START) begin
                        state_q <= SHIFT;
                        sh_q    <= frame_d;
                        cnt_q   <= '0;
                        so_q    <= frame_d[0];
                        sv_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (sv_q && bus.SR) begin
                        if (cnt_q == CW'(L - 1)) begin
                            state_q <= FIN;
                            so_q    <= 1'b0;
                            sv_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                            sh_q  <= sh_q >> 1;
                            so_q  <= sh_q[1];
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.SO   = so_q;
    assign bus.SV   = sv_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
endmodule

// File: tb/tb_gal_olmc_readback.sv
// tb_gal_olmc_readback: scoreboard bench with a frame-level reference model
module tb_gal_olmc_readback;
    localparam int N = 8;
    localparam int L = 4 + 3 * N + 1;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   cyc;
    int   mode = 0;
    logic done_due = 1'b0;
    exp_t q[$];

    gal_olmc_readback_if #(.N_OLMC(N)) bus ();

    gal_olmc_readback #(.N_OLMC(N), .HEADER(4'b1010)) dut (
        .C(clk),
        .R(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: frame from the bit-order rules, parity by counting ones
    task automatic push_frame(input logic [N-1:0] r, input logic [N-1:0] i, input logic [N-1:0] p);
        logic [3:0] h;
        int ones;
        h = 4'b1010;
        ones = 0;
        for (int k = 3; k >= 0; k--) q.push_back('{b: h[k], last: 1'b0});
        for (int c = 0; c < N; c++) begin
            q.push_back('{b: r[c], last: 1'b0});
            q.push_back('{b: i[c], last: 1'b0});
            q.push_back('{b: p[c], last: 1'b0});
            ones += int'(r[c]) + int'(i[c]) + int'(p[c]);
        end
        q.push_back('{b: (ones % 2) == 1, last: 1'b1});
    endtask

    task automatic capture(input logic [N-1:0] r, input logic [N-1:0] i, input logic [N-1:0] p);
        bus.CFG_REG = r;
        bus.CFG_INV = i;
        bus.PIN = p;
        bus.START = 1'b1;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
        push_frame(r, i, p);
        cyc = 1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.DONE && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            cyc++;
        end
        if (n >= 400) chk("done_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // SR driver: always ready, the 1,0,0,1 pattern, or random
    initial begin
        int ph;
        ph = 0;
        bus.SR = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (mode == 0) bus.SR = 1'b1;
            else if (mode == 1) bus.SR = (ph % 4 == 0) || (ph % 4 == 3);
            else bus.SR = 1'($urandom_range(0, 1));
            ph++;
        end
    end

    // Monitor: compare every presented bit against the scoreboard and check status outputs
    always @(negedge clk) begin
        if (rst_n) begin
            if (done_due) begin
                chk("done_pulse", int'(bus.DONE), 1);
                done_due = 1'b0;
            end else if (bus.DONE) begin
                chk("spurious_done", int'(bus.DONE), 0);
            end
            chk("busy", int'(bus.BUSY), int'(q.size() != 0));
            chk("sv", int'(bus.SV), int'(q.size() != 0));
            if (bus.SV && q.size() != 0) begin
                chk("so", int'(bus.SO), int'(q[0].b));
                if (bus.SR) begin
                    if (q[0].last) done_due = 1'b1;
                    void'(q.pop_front());
                end
            end else begin
                chk("so_idle", int'(bus.SO), 0);
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        bus.START = 1'b0;
        bus.CFG_REG = '0;
        bus.CFG_INV = '0;
        bus.PIN = '0;
        idle(3);
        chk("rst_so", int'(bus.SO), 0);
        chk("rst_sv", int'(bus.SV), 0);
        chk("rst_busy", int'(bus.BUSY), 0);
        chk("rst_done", int'(bus.DONE), 0);
        rst_n = 1'b1;
        idle(2);

        capture('0, '0, '0);
        wait_done();
        chk("done_latency", cyc, L + 1);
        idle(3);

        capture(8'h01, 8'h80, 8'h03);
        wait_done();
        idle(2);

        capture(8'h01, 8'h00, 8'h00);
        bus.PIN = 8'hFF;
        bus.CFG_INV = 8'h5A;
        wait_done();
        idle(2);

        mode = 1;
        capture(8'h01, 8'h80, 8'h03);
        wait_done();
        idle(2);
        mode = 0;

        capture(8'($urandom), 8'($urandom), 8'($urandom));
        n = 0;
        while (q.size() > L - 10 && n < 400) begin
            idle(1);
            n++;
        end
        bus.START = 1'b1;
        idle(1);
        bus.START = 1'b0;
        wait_done();
        bus.START = 1'b1;
        idle(1);
        bus.START = 1'b0;
        idle(4);

        capture(8'hC3, 8'h3C, 8'hA5);
        wait_done();
        bus.CFG_REG = 8'h96;
        bus.CFG_INV = 8'h0F;
        bus.PIN = 8'hE1;
        bus.START = 1'b1;
        idle(1);
        idle(1);
        bus.START = 1'b0;
        push_frame(8'h96, 8'h0F, 8'hE1);
        wait_done();
        idle(2);

        mode = 2;
        capture(8'($urandom), 8'($urandom), 8'($urandom));
        n = 0;
        while (q.size() > L - 15 && n < 400) begin
            idle(1);
            n++;
        end
        rst_n = 1'b0;
        q.delete();
        done_due = 1'b0;
        #1;
        chk("midrst_so", int'(bus.SO), 0);
        chk("midrst_sv", int'(bus.SV), 0);
        chk("midrst_busy", int'(bus.BUSY), 0);
        chk("midrst_done", int'(bus.DONE), 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        capture(8'($urandom), 8'($urandom), 8'($urandom));
        wait_done();
        idle(2);

        for (int f = 0; f < 8; f++) begin
            mode = int'($urandom_range(0, 2));
            capture(8'($urandom), 8'($urandom), 8'($urandom));
            bus.PIN = 8'($urandom);
            bus.CFG_REG = 8'($urandom);
            wait_done();
            idle(int'($urandom_range(1, 3)));
        end

        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gal_olmc_readback.md
Name: gal_olmc_readback

Overview:
- Readback/verification reader for the GAL output-macrocell (OLMC) layer.
- On request, snapshots each OLMC's configuration bits (REGISTERED, INVERTED) and its live pin value Y.
- Serialises the snapshot as a framed, parity-protected bit stream with a valid/ready handshake.
- Gives the programmer/test harness a way to read back what the mapping flow wrote into the macrocells.

Parameters:
- N_OLMC, 8: number of macrocells captured; legal 1..10.
- HEADER, 4'b1010: 4-bit frame sync pattern, sent MSB first.

Ports:
- C  input  1  clock; all state updates on rising edge.
- R  input  1  reset, asynchronous, active-low.
- START  input  1  request a readback; sampled only in IDLE.
- CFG_REG  input  N_OLMC  per-cell REGISTERED config bit; bit i = cell i.
- CFG_INV  input  N_OLMC  per-cell INVERTED config bit.
- PIN  input  N_OLMC  per-cell Y pin value; already synchronous to C.
- SO  output  1  serial data bit.
- SV  output  1  SO valid.
- SR  input  1  consumer ready; a bit transfers on a cycle with SV=1 and SR=1.
- BUSY  output  1  high from capture until the last bit transfers.
- DONE  output  1  one-cycle pulse after the final bit transfers.

Behaviour:
- Frame length L = 4 + 3*N_OLMC + 1 bits (29 for N_OLMC=8).
- Bit order:
  - HEADER[3..0].
  - Then for i = 0..N_OLMC-1: CFG_REG[i], CFG_INV[i], PIN[i].
  - Then P = XOR of the 3*N_OLMC payload bits (even parity; header excluded).
- Bit counter width: clog2(L).
- States:
  - IDLE
    - SV=0, BUSY=0, SO=0.
    - START=1 at a clock edge: capture CFG_REG/CFG_INV/PIN and compute P in that same edge, load the shift register, bit counter=0, go to SHIFT.
  - SHIFT
    - BUSY=1, SV=1, SO = frame bit [counter].
    - On SV&SR: if counter < L-1, increment counter and present the next bit on the following cycle.
    - On SV&SR with counter = L-1: go to FIN.
    - SR=0: hold SO, SV and counter unchanged; no timeout.
  - FIN
    - SV=0, BUSY=0, DONE=1 for exactly one cycle, then IDLE.
- Latency:
  - First bit valid one cycle after the START edge.
  - With SR held high, DONE is asserted L+1 cycles after the START edge.
- Snapshot rule: inputs changing after the capture edge do not alter the frame in flight.
- START while in SHIFT or FIN is ignored and not queued.
  - START=1 in the FIN cycle is ignored.
  - START held high through FIN into IDLE starts a new frame from the IDLE edge.
- Reset (R=0, any time, including mid-frame):
  - State goes to IDLE immediately; counter=0; shift register cleared.
  - SO=0, SV=0, BUSY=0, DONE=0; the partial frame is discarded.
  - After R deasserts, the first rising edge behaves as IDLE.
- Outputs are registered; no combinational path from SR or START to SO/SV/DONE.

Test Plan:
- N_OLMC=8, SR tied 1, CFG_REG=8'h00, CFG_INV=8'h00, PIN=8'h00, pulse START -> SO = 1,0,1,0 followed by 25 zeros; P=0; SV high 29 cycles; DONE pulses on cycle 30 after START.
- CFG_REG=8'h01, CFG_INV=8'h80, PIN=8'h03, SR=1 -> payload triplets: cell0=1,0,1; cell1=0,0,1; cell7=0,1,0; others 0,0,0; P=0 (4 ones).
- CFG_REG=8'h01, others 0 -> P=1. Change PIN to 8'hFF one cycle after START -> frame unchanged.
- SR toggled 1,0,0,1 repeating during SHIFT -> each bit held stable while SR=0; full 29-bit sequence identical to the SR=1 case; DONE only after the 29th handshake.
- Assert START again at bit 10 and during FIN -> ignored, single frame, BUSY never drops early.
- Assert R=0 at bit 15 -> SV, BUSY, SO low immediately, no DONE; release R, START -> a complete fresh frame starting with header 1010.
